// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode, state, select-code and field-slice constants for the 16-bit RISC core
package risc_pkg;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LDI   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_ALU    = 3'd5;
    localparam logic [2:0] S_LDI    = 3'd6;
    localparam logic [2:0] S_JMPZ   = 3'd7;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] WR_SEL_ALU = 2'b00;
    localparam logic [1:0] WR_SEL_MEM = 2'b01;
    localparam logic [1:0] WR_SEL_IMM = 2'b10;

    localparam int OP_HI = 15;
    localparam int RA_HI = 11;
    localparam int RA_LO = 8;
    localparam int RB_HI = 7;
    localparam int RB_LO = 4;
    localparam int RC_HI = 3;
    localparam int RC_LO = 0;
    localparam int D_HI  = 7;
    localparam int D_LO  = 0;

endpackage

// File: rtl/risc_ir.sv
// rtl/risc_ir.sv - 16-bit instruction register with async active-low clear and load enable
module risc_ir (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= 16'h0000;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/risc_control_unit.sv
// rtl/risc_control_unit.sv - multi-cycle fetch/decode/execute controller driving the RISC datapath
module risc_control_unit
    import risc_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       mem_out,
    input  logic              rp_zero,
    output logic [15:0]       instruction,
    output logic [2:0]        state,
    output logic [2:0]        alu_sel,
    output logic [1:0]        rf_wr_sel,
    output logic              mem_addr_sel,
    output logic              rf_Rp_rd,
    output logic              rf_Rq_rd,
    output logic              rf_wr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [3:0]        rf_addr_Rp,
    output logic [3:0]        rf_addr_Rq,
    output logic [3:0]        rf_addr_Wr,
    output logic [ADDR_W-1:0] D_addr,
    output logic [ADDR_W-1:0] immediate,
    output logic              IR_ld,
    output logic              PC_inc,
    output logic              PC_clr,
    output logic              PC_ld
);

    logic [2:0]       next_state;
    logic [OPC_W-1:0] op;
    logic [3:0]       ra, rb, rc;

    risc_ir u_ir (
        .clk   (clk),
        .reset (reset),
        .ld    (IR_ld),
        .d     (mem_out),
        .q     (instruction)
    );

    assign op        = instruction[OP_HI -: OPC_W];
    assign ra        = instruction[RA_HI:RA_LO];
    assign rb        = instruction[RB_HI:RB_LO];
    assign rc        = instruction[RC_HI:RC_LO];
    assign D_addr    = instruction[D_HI:D_LO];
    assign immediate = instruction[D_HI:D_LO];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_INIT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_INIT:  next_state = S_FETCH;
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD:        next_state = S_LOAD;
                    OP_STORE:       next_state = S_STORE;
                    OP_ADD, OP_SUB: next_state = S_ALU;
                    OP_LDI:         next_state = S_LDI;
                    OP_JMPZ:        next_state = S_JMPZ;
                    default:        next_state = S_FETCH;
                endcase
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Register addresses stay zero outside the states that use them so the RF sees clean selects.
    always_comb begin
        alu_sel      = ALU_PASS;
        rf_wr_sel    = WR_SEL_ALU;
        mem_addr_sel = 1'b0;
        rf_Rp_rd     = 1'b0;
        rf_Rq_rd     = 1'b0;
        rf_wr        = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        rf_addr_Rp   = 4'h0;
        rf_addr_Rq   = 4'h0;
        rf_addr_Wr   = 4'h0;
        IR_ld        = 1'b0;
        PC_inc       = 1'b0;
        PC_clr       = 1'b0;
        PC_ld        = 1'b0;
        case (state)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                mem_rd = 1'b1;
                IR_ld  = 1'b1;
                PC_inc = 1'b1;
            end
            S_LOAD: begin
                mem_addr_sel = 1'b1;
                mem_rd       = 1'b1;
                rf_wr        = 1'b1;
                rf_wr_sel    = WR_SEL_MEM;
                rf_addr_Wr   = ra;
            end
            S_STORE: begin
                mem_addr_sel = 1'b1;
                mem_wr       = 1'b1;
                rf_Rp_rd     = 1'b1;
                rf_addr_Rp   = ra;
            end
            S_ALU: begin
                rf_Rp_rd   = 1'b1;
                rf_Rq_rd   = 1'b1;
                rf_addr_Rp = rb;
                rf_addr_Rq = rc;
                rf_addr_Wr = ra;
                rf_wr      = 1'b1;
                rf_wr_sel  = WR_SEL_ALU;
                alu_sel    = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
            S_LDI: begin
                rf_wr      = 1'b1;
                rf_wr_sel  = WR_SEL_IMM;
                rf_addr_Wr = ra;
            end
            S_JMPZ: begin
                // PC already points past the JMPZ, so the datapath adds the offset to it directly.
                rf_Rp_rd   = 1'b1;
                rf_addr_Rp = ra;
                PC_ld      = rp_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// tb/tb_risc_control_unit.sv - directed self-checking bench for risc_control_unit
module tb_risc_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] mem_out;
    logic        rp_zero;
    logic [15:0] instruction;
    logic [2:0]  state;
    logic [2:0]  alu_sel;
    logic [1:0]  rf_wr_sel;
    logic        mem_addr_sel;
    logic        rf_Rp_rd, rf_Rq_rd, rf_wr, mem_rd, mem_wr;
    logic [3:0]  rf_addr_Rp, rf_addr_Rq, rf_addr_Wr;
    logic [7:0]  D_addr, immediate;
    logic        IR_ld, PC_inc, PC_clr, PC_ld;

    int checks = 0;
    int errors = 0;

    risc_control_unit #(.OPC_W(4), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_out      (mem_out),
        .rp_zero      (rp_zero),
        .instruction  (instruction),
        .state        (state),
        .alu_sel      (alu_sel),
        .rf_wr_sel    (rf_wr_sel),
        .mem_addr_sel (mem_addr_sel),
        .rf_Rp_rd     (rf_Rp_rd),
        .rf_Rq_rd     (rf_Rq_rd),
        .rf_wr        (rf_wr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .rf_addr_Rp   (rf_addr_Rp),
        .rf_addr_Rq   (rf_addr_Rq),
        .rf_addr_Wr   (rf_addr_Wr),
        .D_addr       (D_addr),
        .immediate    (immediate),
        .IR_ld        (IR_ld),
        .PC_inc       (PC_inc),
        .PC_clr       (PC_clr),
        .PC_ld        (PC_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        mem_out = 16'h0000;
        rp_zero = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin $display("FAIL reset_state got %0d want 0", state); errors++; end
        checks++; if (instruction !== 16'h0000) begin $display("FAIL reset_ir got %h want 0000", instruction); errors++; end
        repeat (3) tick();
        checks++; if ({PC_clr, mem_rd, mem_wr, rf_wr, IR_ld, PC_inc, PC_ld} !== 7'b1000000)
            begin $display("FAIL reset_strobes got %b want 1000000", {PC_clr, mem_rd, mem_wr, rf_wr, IR_ld, PC_inc, PC_ld}); errors++; end
        reset = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || PC_clr !== 1'b1) begin $display("FAIL release_init got state=%0d pc_clr=%b want 0/1", state, PC_clr); errors++; end
        tick();
        checks++; if (state !== 3'd1) begin $display("FAIL fetch_state got %0d want 1", state); errors++; end
        checks++; if ({PC_clr, mem_rd, IR_ld, PC_inc, mem_addr_sel} !== 5'b01110)
            begin $display("FAIL fetch_strobes got %b want 01110", {PC_clr, mem_rd, IR_ld, PC_inc, mem_addr_sel}); errors++; end
    endtask

    task automatic test_ldi();
        mem_out = 16'h3A5C;
        tick();
        checks++; if (state !== 3'd2 || instruction !== 16'h3A5C) begin $display("FAIL ldi_decode got state=%0d ir=%h want 2/3a5c", state, instruction); errors++; end
        checks++; if ({mem_rd, IR_ld, PC_inc, rf_wr} !== 4'b0000) begin $display("FAIL ldi_decode_strobes got %b want 0000", {mem_rd, IR_ld, PC_inc, rf_wr}); errors++; end
        tick();
        checks++; if (state !== 3'd6 || rf_wr !== 1'b1 || rf_wr_sel !== 2'b10)
            begin $display("FAIL ldi_exec got state=%0d wr=%b sel=%b want 6/1/10", state, rf_wr, rf_wr_sel); errors++; end
        checks++; if (rf_addr_Wr !== 4'hA || immediate !== 8'h5C)
            begin $display("FAIL ldi_fields got wr=%h imm=%h want a/5c", rf_addr_Wr, immediate); errors++; end
        tick();
        checks++; if (state !== 3'd1 || rf_wr !== 1'b0) begin $display("FAIL ldi_return got state=%0d wr=%b want 1/0", state, rf_wr); errors++; end
    endtask

    task automatic test_alu();
        mem_out = 16'h2123;
        tick(); tick();
        checks++; if (state !== 3'd5 || alu_sel !== 3'b001) begin $display("FAIL add_exec got state=%0d alu=%b want 5/001", state, alu_sel); errors++; end
        checks++; if ({rf_addr_Rp, rf_addr_Rq, rf_addr_Wr} !== 12'h231 || {rf_Rp_rd, rf_Rq_rd, rf_wr} !== 3'b111 || rf_wr_sel !== 2'b00)
            begin $display("FAIL add_regs got %h %b %b want 231 111 00", {rf_addr_Rp, rf_addr_Rq, rf_addr_Wr}, {rf_Rp_rd, rf_Rq_rd, rf_wr}, rf_wr_sel); errors++; end
        tick();
        checks++; if (state !== 3'd1) begin $display("FAIL add_return got %0d want 1", state); errors++; end
        mem_out = 16'h4456;
        tick(); tick();
        checks++; if (state !== 3'd5 || alu_sel !== 3'b010) begin $display("FAIL sub_exec got state=%0d alu=%b want 5/010", state, alu_sel); errors++; end
        checks++; if ({rf_addr_Rp, rf_addr_Rq, rf_addr_Wr} !== 12'h564)
            begin $display("FAIL sub_regs got %h want 564", {rf_addr_Rp, rf_addr_Rq, rf_addr_Wr}); errors++; end
        tick();
        checks++; if (state !== 3'd1 || rf_wr !== 1'b0) begin $display("FAIL sub_return got state=%0d wr=%b want 1/0", state, rf_wr); errors++; end
    endtask

    task automatic test_load_store();
        mem_out = 16'h0710;
        tick(); tick();
        checks++; if (state !== 3'd3 || mem_addr_sel !== 1'b1 || D_addr !== 8'h10)
            begin $display("FAIL load_addr got state=%0d sel=%b d=%h want 3/1/10", state, mem_addr_sel, D_addr); errors++; end
        checks++; if ({mem_rd, rf_wr, mem_wr} !== 3'b110 || rf_wr_sel !== 2'b01 || rf_addr_Wr !== 4'h7)
            begin $display("FAIL load_ctl got %b sel=%b wr=%h want 110/01/7", {mem_rd, rf_wr, mem_wr}, rf_wr_sel, rf_addr_Wr); errors++; end
        tick();
        mem_out = 16'h1710;
        tick(); tick();
        checks++; if (state !== 3'd4 || mem_addr_sel !== 1'b1 || D_addr !== 8'h10)
            begin $display("FAIL store_addr got state=%0d sel=%b d=%h want 4/1/10", state, mem_addr_sel, D_addr); errors++; end
        checks++; if ({mem_wr, rf_Rp_rd, rf_wr, mem_rd} !== 4'b1100 || rf_addr_Rp !== 4'h7)
            begin $display("FAIL store_ctl got %b rp=%h want 1100/7", {mem_wr, rf_Rp_rd, rf_wr, mem_rd}, rf_addr_Rp); errors++; end
        tick();
        checks++; if (state !== 3'd1 || mem_wr !== 1'b0) begin $display("FAIL store_return got state=%0d wr=%b want 1/0", state, mem_wr); errors++; end
    endtask

    task automatic test_jmpz();
        rp_zero = 1'b1;
        mem_out = 16'h52FE;
        tick(); tick();
        checks++; if (state !== 3'd7 || PC_ld !== 1'b1 || PC_inc !== 1'b0 || immediate !== 8'hFE)
            begin $display("FAIL jmpz_taken got state=%0d ld=%b inc=%b imm=%h want 7/1/0/fe", state, PC_ld, PC_inc, immediate); errors++; end
        checks++; if (rf_Rp_rd !== 1'b1 || rf_addr_Rp !== 4'h2) begin $display("FAIL jmpz_rp got rd=%b rp=%h want 1/2", rf_Rp_rd, rf_addr_Rp); errors++; end
        rp_zero = 1'b0;
        #1;
        checks++; if (PC_ld !== 1'b0) begin $display("FAIL jmpz_comb got %b want 0", PC_ld); errors++; end
        rp_zero = 1'b1;
        tick();
        checks++; if (state !== 3'd1 || PC_ld !== 1'b0) begin $display("FAIL jmpz_taken_len got state=%0d ld=%b want 1/0", state, PC_ld); errors++; end
        rp_zero = 1'b0;
        tick(); tick();
        checks++; if (state !== 3'd7 || PC_ld !== 1'b0) begin $display("FAIL jmpz_not_taken got state=%0d ld=%b want 7/0", state, PC_ld); errors++; end
        tick();
        checks++; if (state !== 3'd1) begin $display("FAIL jmpz_nt_len got %0d want 1", state); errors++; end
    endtask

    task automatic test_nop();
        mem_out = 16'hF000;
        tick();
        checks++; if (state !== 3'd2 || instruction !== 16'hF000) begin $display("FAIL nop_decode got state=%0d ir=%h want 2/f000", state, instruction); errors++; end
        checks++; if ({PC_clr, mem_rd, mem_wr, rf_wr, rf_Rp_rd, rf_Rq_rd, IR_ld, PC_inc, PC_ld, mem_addr_sel} !== 10'b0)
            begin $display("FAIL nop_strobes got %b want 0", {PC_clr, mem_rd, mem_wr, rf_wr, rf_Rp_rd, rf_Rq_rd, IR_ld, PC_inc, PC_ld, mem_addr_sel}); errors++; end
        tick();
        checks++; if (state !== 3'd1) begin $display("FAIL nop_return got %0d want 1", state); errors++; end
    endtask

    task automatic test_abort();
        mem_out = 16'h2123;
        tick(); tick();
        checks++; if (state !== 3'd5 || rf_wr !== 1'b1) begin $display("FAIL abort_pre got state=%0d wr=%b want 5/1", state, rf_wr); errors++; end
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || rf_wr !== 1'b0 || instruction !== 16'h0000 || PC_clr !== 1'b1)
            begin $display("FAIL abort got state=%0d wr=%b ir=%h clr=%b want 0/0/0000/1", state, rf_wr, instruction, PC_clr); errors++; end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (state !== 3'd1) begin $display("FAIL abort_restart got %0d want 1", state); errors++; end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_load_store();
        test_jmpz();
        test_nop();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
